adder_sum_stage: RTL and testbench

Pipelined final stage of the parallel-prefix adder. Consumes the per-bit half-sum vector and the fully-resolved group-generate vector from the last prefix stage. Produces the registered sum, carry-out and ALU flags behind a valid/ready handshake, so the prefix tree stays combinational and the ALU result path gains two elastic register slices.

---
 rtl/adder_sum_stage_pkg.sv | 19 +
 rtl/adder_flag_gen.sv | 33 +++
 rtl/adder_sum_stage.sv | 111 +++++++++++
 tb/tb_adder_sum_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_sum_stage_pkg.sv
// Shared constants and payload types for the adder sum stage.
//   LEN_DATA   : MSB index of the adder datapath (datapath is LEN_DATA+1 bits)
//   ADD_TAG_W  : default width of the opaque tag carried with each operation
//   add_result_t : sum plus ALU flags produced from one resolved operand set
package adder_sum_stage_pkg;

  localparam int unsigned LEN_DATA  = 63;
  localparam int unsigned ADD_TAG_W = 4;
  localparam int unsigned DATA_W    = LEN_DATA + 1;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              carry;
    logic              overflow;
    logic              zero;
    logic              neg;
  } add_result_t;

endpackage

// File: rtl/adder_flag_gen.sv
// Combinational sum and flag generation from half-sum and group-generate.
// Ports:
//   half_sum   in  per-bit a^b
//   group_gen  in  G[i:0] for every bit i, carry-in already folded into bit 0
//   carry_in   in  adder carry-in, the carry into bit 0
//   result_c   out sum, carry-out, signed overflow, zero and negative flags
module adder_flag_gen
  import adder_sum_stage_pkg::*;
(
  input  logic [DATA_W-1:0] half_sum,
  input  logic [DATA_W-1:0] group_gen,
  input  logic              carry_in,
  output add_result_t       result_c
);

  logic [DATA_W-1:0] carries;
  logic [DATA_W-1:0] sum;

  // Carry into bit i is the group generate of bits below it.
  assign carries = {group_gen[DATA_W-2:0], carry_in};
  assign sum     = half_sum ^ carries;

  always_comb begin
    result_c          = '0;
    result_c.sum      = sum;
    result_c.carry    = group_gen[DATA_W-1];
    // Carry into the MSB differs from carry out of the MSB.
    result_c.overflow = group_gen[DATA_W-2] ^ group_gen[DATA_W-1];
    result_c.zero     = ~|sum;
    result_c.neg      = sum[DATA_W-1];
  end

endmodule

// File: rtl/adder_sum_stage.sv
// Final pipelined stage of the parallel-prefix adder: two elastic register
// slices around the sum/flag logic, with a valid/ready handshake on each side.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid, in_ready            upstream handshake
//   half_sum_in, generate_in      resolved prefix-tree outputs
//   carry_in, tag_in              carry into bit 0, opaque tag
//   out_valid, out_ready          downstream handshake
//   sum_out, carry_out,           registered result and flags
//   overflow_out, zero_out,
//   neg_out, tag_out
module adder_sum_stage
  import adder_sum_stage_pkg::*;
#(
  parameter int unsigned TAG_W = ADD_TAG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LEN_DATA:0]   half_sum_in,
  input  logic [LEN_DATA:0]   generate_in,
  input  logic                carry_in,
  input  logic [TAG_W-1:0]    tag_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LEN_DATA:0]   sum_out,
  output logic                carry_out,
  output logic                overflow_out,
  output logic                zero_out,
  output logic                neg_out,
  output logic [TAG_W-1:0]    tag_out
);

  // S1 slice: raw operands, no arithmetic before the register.
  logic              s1_valid;
  logic [DATA_W-1:0] s1_half_sum;
  logic [DATA_W-1:0] s1_gen;
  logic              s1_carry_in;
  logic [TAG_W-1:0]  s1_tag;

  // S2 slice: finished result, drives the outputs directly.
  logic              s2_valid;
  add_result_t       s2_res;
  logic [TAG_W-1:0]  s2_tag;

  add_result_t       res_c;
  logic              s2_free;
  logic              advance;
  logic              accept;

  adder_flag_gen u_flag_gen (
    .half_sum  (s1_half_sum),
    .group_gen (s1_gen),
    .carry_in  (s1_carry_in),
    .result_c  (res_c)
  );

  // Handshake: S2 frees when empty or being drained; S1 frees when it advances.
  assign s2_free  = !s2_valid || out_ready;
  assign advance  = s1_valid && s2_free;
  assign in_ready = !rst && (!s1_valid || s2_free);
  assign accept   = in_valid && in_ready;

  // S1 slice register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_half_sum <= '0;
      s1_gen      <= '0;
      s1_carry_in <= 1'b0;
      s1_tag      <= '0;
    end else begin
      if (accept) begin
        s1_valid    <= 1'b1;
        s1_half_sum <= half_sum_in;
        s1_gen      <= generate_in;
        s1_carry_in <= carry_in;
        s1_tag      <= tag_in;
      end else if (advance) begin
        s1_valid    <= 1'b0;
      end
    end
  end

  // S2 slice register; data holds while stalled or empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_tag   <= '0;
    end else begin
      if (advance) begin
        s2_valid <= 1'b1;
        s2_res   <= res_c;
        s2_tag   <= s1_tag;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = s2_valid;
  assign sum_out      = s2_res.sum;
  assign carry_out    = s2_res.carry;
  assign overflow_out = s2_res.overflow;
  assign zero_out     = s2_res.zero;
  assign neg_out      = s2_res.neg;
  assign tag_out      = s2_tag;

endmodule

// File: tb/tb_adder_sum_stage.sv
// Self-checking bench for adder_sum_stage. Operands a, b, cin are chosen by
// the bench; the prefix-tree outputs are derived from them arithmetically and
// results are predicted as a+b+cin in a scoreboard queue.
module tb_adder_sum_stage;

  localparam int unsigned W  = 64;
  localparam int unsigned TW = 4;

  typedef struct packed {
    logic [W-1:0]  sum;
    logic          carry;
    logic          overflow;
    logic          zero;
    logic          neg;
    logic [TW-1:0] tag;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  half_sum_in;
  logic [W-1:0]  generate_in;
  logic          carry_in;
  logic [TW-1:0] tag_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum_out;
  logic          carry_out;
  logic          overflow_out;
  logic          zero_out;
  logic          neg_out;
  logic [TW-1:0] tag_out;

  adder_sum_stage #(.TAG_W(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .half_sum_in  (half_sum_in),
    .generate_in  (generate_in),
    .carry_in     (carry_in),
    .tag_in       (tag_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sum_out      (sum_out),
    .carry_out    (carry_out),
    .overflow_out (overflow_out),
    .zero_out     (zero_out),
    .neg_out      (neg_out),
    .tag_out      (tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Drive values applied by cyc() at the next falling edge.
  logic          d_rst, d_valid, d_cin, d_ordy;
  logic [W-1:0]  d_a, d_b;
  logic [TW-1:0] d_tag;

  exp_t          exp_q[$];
  logic [TW-1:0] seen_tags[$];
  logic          last_acc, last_in_ready, last_valid;
  logic          prev_stall;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // G[i] = carry out of bit i, i.e. carry out of the low (i+1)-bit addition.
  function automatic logic [W-1:0] gen_of(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    logic [W-1:0] g;
    logic [W-1:0] m;
    logic [W:0]   s;
    g = '0;
    for (int i = 0; i < W; i++) begin
      m = (i == W - 1) ? {W{1'b1}} : ((64'd1 << (i + 1)) - 64'd1);
      s = {1'b0, a & m} + {1'b0, b & m} + 65'(cin);
      g[i] = s[i + 1];
    end
    return g;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic [TW-1:0] t);
    exp_t       e;
    logic [W:0] full;
    full       = {1'b0, a} + {1'b0, b} + 65'(cin);
    e.sum      = full[W-1:0];
    e.carry    = full[W];
    e.overflow = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    e.zero     = (full[W-1:0] == '0);
    e.neg      = full[W-1];
    e.tag      = t;
    return e;
  endfunction

  // One clock cycle: apply drives, sample settled values, update scoreboard.
  task automatic cyc();
    exp_t got;
    @(negedge clk);
    rst         = d_rst;
    in_valid    = d_valid;
    half_sum_in = d_a ^ d_b;
    generate_in = gen_of(d_a, d_b, d_cin);
    carry_in    = d_cin;
    tag_in      = d_tag;
    out_ready   = d_ordy;
    #1;
    if (prev_stall) check("valid_hold", 128'(out_valid), 128'(1));
    if (out_valid) begin
      got = {sum_out, carry_out, overflow_out, zero_out, neg_out, tag_out};
      if (exp_q.size() == 0) begin
        check("spurious_valid", 128'(out_valid), 128'(0));
      end else begin
        check("result", 128'(got), 128'(exp_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          seen_tags.push_back(tag_out);
        end
      end
    end
    last_acc      = in_valid && in_ready;
    last_in_ready = in_ready;
    last_valid    = out_valid;
    prev_stall    = out_valid && !out_ready && !rst;
    if (last_acc) exp_q.push_back(model(d_a, d_b, d_cin, d_tag));
  endtask

  task automatic drain();
    d_valid = 1'b0;
    d_ordy  = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || last_valid); i++) cyc();
    check("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic check_all_zero(input string name);
    check(name, 128'({out_valid, sum_out, carry_out, overflow_out, zero_out, neg_out, tag_out}),
          128'(0));
  endtask

  int            k;
  int            n_acc;
  logic          vseen[14];

  initial begin
    d_rst = 1'b1; d_valid = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_tag = '0; d_ordy = 1'b0;
    rst = 1'b1; in_valid = 1'b0; half_sum_in = '0; generate_in = '0; carry_in = 1'b0;
    tag_in = '0; out_ready = 1'b0;
    prev_stall = 1'b0; last_valid = 1'b0; last_acc = 1'b0; last_in_ready = 1'b0;

    // Reset state: in_ready low during reset, outputs all zero.
    d_valid = 1'b1;
    cyc(); cyc();
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check_all_zero("rst_outputs");
    check("rst_no_accept", 128'(exp_q.size()), 128'(0));
    d_rst = 1'b0; d_valid = 1'b0;
    cyc();
    check("post_rst_in_ready", 128'(in_ready), 128'(1));

    // 0xFFFF..FF + 1: wraps to zero with carry out.
    d_ordy = 1'b1; d_valid = 1'b1; d_a = '1; d_b = 64'd1; d_cin = 1'b0; d_tag = 4'd5;
    cyc();
    check("wrap_accept", 128'(last_acc), 128'(1));
    d_valid = 1'b0;
    cyc();
    check("wrap_latency_early", 128'(out_valid), 128'(0));
    cyc();
    check("wrap_out", 128'({out_valid, sum_out, carry_out, zero_out, overflow_out, neg_out}),
          128'({1'b1, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0}));
    drain();

    // 0x7FFF..FF + 1: signed overflow into the sign bit.
    d_valid = 1'b1; d_a = 64'h7FFF_FFFF_FFFF_FFFF; d_b = 64'd1; d_cin = 1'b0; d_tag = 4'd6;
    cyc();
    d_valid = 1'b0;
    cyc(); cyc();
    check("ovf_out", 128'({out_valid, sum_out, carry_out, zero_out, overflow_out, neg_out}),
          128'({1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1}));
    drain();

    // Backpressure: two accepted, third refused, outputs frozen on tag 1.
    seen_tags.delete();
    d_ordy = 1'b0; d_valid = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      d_tag = TW'(t); d_a = {$urandom, $urandom}; d_b = {$urandom, $urandom};
      d_cin = 1'($urandom_range(0, 1));
      cyc();
      check($sformatf("bp_accept_%0d", t), 128'(last_acc), 128'(t < 3));
    end
    cyc(); cyc();
    check("bp_frozen", 128'({out_valid, tag_out}), 128'({1'b1, 4'd1}));
    check("bp_in_ready", 128'(in_ready), 128'(0));
    d_ordy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (last_acc) break;
    end
    check("bp_third_accept", 128'(last_acc), 128'(1));
    drain();
    check("bp_count", 128'(seen_tags.size()), 128'(3));
    for (int i = 0; i < 3 && i < seen_tags.size(); i++)
      check($sformatf("bp_order_%0d", i), 128'(seen_tags[i]), 128'(i + 1));

    // Throughput: 8 back-to-back ops, 8 consecutive valid cycles after 2.
    seen_tags.delete();
    for (int i = 0; i < 14; i++) begin
      d_valid = (i < 8); d_tag = TW'(i);
      d_a = {$urandom, $urandom}; d_b = {$urandom, $urandom};
      d_cin = 1'($urandom_range(0, 1));
      cyc();
      vseen[i] = last_valid;
      if (i < 8) check($sformatf("tput_accept_%0d", i), 128'(last_acc), 128'(1));
    end
    for (int i = 0; i < 14; i++)
      check($sformatf("tput_valid_%0d", i), 128'(vseen[i]), 128'(i >= 2 && i <= 9));
    check("tput_count", 128'(seen_tags.size()), 128'(8));
    for (int i = 0; i < 8 && i < seen_tags.size(); i++)
      check($sformatf("tput_order_%0d", i), 128'(seen_tags[i]), 128'(i));
    drain();

    // Reset mid-flight discards both slices.
    d_ordy = 1'b0; d_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d_tag = TW'(10 + i); d_a = {$urandom, $urandom}; d_b = {$urandom, $urandom};
      cyc();
    end
    d_rst = 1'b1;
    cyc();
    check("midrst_in_ready", 128'(in_ready), 128'(0));
    exp_q.delete();
    d_rst = 1'b0; d_valid = 1'b0; d_ordy = 1'b1;
    cyc();
    check_all_zero("midrst_outputs");
    for (int i = 0; i < 4; i++) cyc();
    check("midrst_no_stale", 128'(last_valid), 128'(0));

    // Random traffic against the arithmetic model.
    n_acc = 0;
    k = 0;
    while (n_acc < 10000 && k < 60000) begin
      d_valid = ($urandom_range(0, 3) != 0);
      d_ordy  = ($urandom_range(0, 3) != 0);
      d_a     = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       d_b = ~d_a;
        1:       d_b = '0;
        2:       d_b = '1;
        default: d_b = {$urandom, $urandom};
      endcase
      d_cin = 1'($urandom_range(0, 1));
      d_tag = TW'($urandom);
      cyc();
      if (last_acc) n_acc++;
      k++;
    end
    check("random_budget", 128'(n_acc), 128'(10000));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
